// File: rtl/output_writeback_pkg.sv
// Shared accelerator definitions for the output writeback path: FSM state
// encoding and the signed saturation limits used when narrowing results.
package output_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_e;

  function automatic longint wb_sat_hi(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint wb_sat_lo(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/output_writeback_if.sv
// Result stream from the conv core plus the memory write stream, both valid/ready.
// master = environment side (core + memory), slave = the writeback block.
interface output_writeback_if #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 16
);
  localparam int X_W        = $clog2(FEATURE_MAP_WIDTH);
  localparam int Y_W        = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CH_W       = $clog2(OUTPUT_NB_CHANNELS);
  localparam int ADDR_WIDTH = $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

  logic                                 in_valid;
  logic                                 in_ready;
  logic signed [ACCUMULATION_WIDTH-1:0] in_data;
  logic [X_W-1:0]                       in_x;
  logic [Y_W-1:0]                       in_y;
  logic [CH_W-1:0]                      in_ch;
  logic                                 out_valid;
  logic                                 out_ready;
  logic signed [IO_DATA_WIDTH-1:0]      out_data;
  logic [ADDR_WIDTH-1:0]                out_addr;

  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/adder.sv
// Plain combinational two-operand adder, shared so arithmetic can be accounted per instance.
// Zero latency; wraps modulo 2^WIDTH.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

// File: rtl/wb_fifo.sv
// Registered FIFO, valid/ready on both sides; a push is visible at the output one cycle later.
// in_rdy_o reflects only "not full", so a full FIFO refuses a push even if it is popping.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_dat_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push, pop;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty     = (wr_q == rd_q);
  assign in_rdy_o  = !full;
  assign out_vld_o = !empty;
  assign out_dat_o = mem_q[rd_q[PW-1:0]];
  assign push      = in_vld_i && in_rdy_o;
  assign pop       = out_vld_o && out_rdy_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[PW-1:0]] <= in_dat_i;
        wr_q                <= wr_q + (PW+1)'(1);
      end
      if (pop) rd_q <= rd_q + (PW+1)'(1);
    end
  end
endmodule

// File: rtl/output_writeback.sv
// Requantises conv results (round, shift, optional ReLU, saturate), tags them with a flat
// address and buffers them for memory writes; 1-cycle latency, in_ready drops when the FIFO is full.
module output_writeback
  import output_writeback_pkg::*;
#(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                clk,
  input  logic                arst_n_in,
  input  logic                start,
  input  logic [23:0]         total_words,
  input  logic [4:0]          shift_amount,
  input  logic                relu_en,
  output_writeback_if.slave   bus,
  output logic                busy,
  output logic                done
);
  localparam int A          = ACCUMULATION_WIDTH;
  localparam int ADDR_WIDTH = $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);
  localparam logic signed [A:0] SAT_HI = (A+1)'(wb_sat_hi(IO_DATA_WIDTH));
  localparam logic signed [A:0] SAT_LO = (A+1)'(wb_sat_lo(IO_DATA_WIDTH));

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [IO_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_state_e   state_q, state_d;
  logic [23:0] total_q, acc_cnt_q, out_cnt_q;
  logic [4:0]  shift_q;
  logic        relu_q;

  logic        accept_open, fifo_in_rdy, fifo_out_vld, push, pop;
  wb_entry_t   wr_entry, rd_entry;

  logic signed [A:0]        acc_ext, bias, sum, shifted, clipped;
  logic [IO_DATA_WIDTH-1:0] q_data;
  logic [ADDR_WIDTH-1:0]    addr_w;

  assign accept_open   = (state_q == RUN) && (acc_cnt_q != total_q);
  assign bus.in_ready  = accept_open && fifo_in_rdy;
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = fifo_out_vld;
  assign pop           = fifo_out_vld && bus.out_ready;
  assign bus.out_data  = rd_entry.data;
  assign bus.out_addr  = rd_entry.addr;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);

  // One guard bit above the accumulator keeps the rounding add from overflowing.
  assign acc_ext = {bus.in_data[A-1], bus.in_data};
  assign bias    = (shift_q == 5'd0) ? '0 : ((A+1)'(1) << (shift_q - 5'd1));

  adder #(.WIDTH(A+1)) u_round_add (
    .a_i   (acc_ext),
    .b_i   (bias),
    .sum_o (sum)
  );

  assign shifted = sum >>> shift_q;

  always_comb begin
    clipped = shifted;
    if (relu_q && (shifted < 0)) clipped = '0;
    if (clipped > SAT_HI)      q_data = SAT_HI[IO_DATA_WIDTH-1:0];
    else if (clipped < SAT_LO) q_data = SAT_LO[IO_DATA_WIDTH-1:0];
    else                       q_data = clipped[IO_DATA_WIDTH-1:0];
  end

  assign addr_w = (ADDR_WIDTH'(bus.in_y) * ADDR_WIDTH'(FEATURE_MAP_WIDTH) + ADDR_WIDTH'(bus.in_x))
                  * ADDR_WIDTH'(OUTPUT_NB_CHANNELS) + ADDR_WIDTH'(bus.in_ch);
  assign wr_entry = '{addr: addr_w, data: q_data};

  wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk),
    .arst_n_i  (arst_n_in),
    .in_vld_i  (bus.in_valid && accept_open),
    .in_rdy_o  (fifo_in_rdy),
    .in_dat_i  (wr_entry),
    .out_vld_o (fifo_out_vld),
    .out_rdy_i (bus.out_ready),
    .out_dat_o (rd_entry)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (total_words == 24'd0) ? DONE : RUN;
      RUN:     if (pop && (out_cnt_q + 24'd1 == total_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q   <= IDLE;
      total_q   <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      acc_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        total_q   <= total_words;
        shift_q   <= shift_amount;
        relu_q    <= relu_en;
        acc_cnt_q <= '0;
        out_cnt_q <= '0;
      end else begin
        if (push) acc_cnt_q <= acc_cnt_q + 24'd1;
        if (pop)  out_cnt_q <= out_cnt_q + 24'd1;
      end
    end
  end
endmodule

// File: tb/tb_output_writeback.sv
// Directed bench for output_writeback: stimulus pushes hand-computed expectations into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_output_writeback;
  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        start;
  logic [23:0] total_words;
  logic [4:0]  shift_amount;
  logic        relu_en;
  logic        busy, done;

  always #5 clk = ~clk;

  output_writeback_if #(
    .ACCUMULATION_WIDTH(32), .IO_DATA_WIDTH(16), .FEATURE_MAP_WIDTH(128),
    .FEATURE_MAP_HEIGHT(128), .OUTPUT_NB_CHANNELS(16)
  ) bus ();

  output_writeback #(
    .ACCUMULATION_WIDTH(32), .IO_DATA_WIDTH(16), .FEATURE_MAP_WIDTH(128),
    .FEATURE_MAP_HEIGHT(128), .OUTPUT_NB_CHANNELS(16), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .start        (start),
    .total_words  (total_words),
    .shift_amount (shift_amount),
    .relu_en      (relu_en),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_hs_cyc = -10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (arst_n_in && bus.out_valid && bus.out_ready) begin
      last_hs_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got addr %0d data 0x%0h, required no output",
                 bus.out_addr, bus.out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'($unsigned(bus.out_data)), 32'(e.data));
        check("out_addr", 32'(bus.out_addr), 32'(e.addr));
      end
    end
  end

  task automatic begin_layer(input logic [23:0] n, input logic [4:0] sh, input logic r);
    start        = 1'b1;
    total_words  = n;
    shift_amount = sh;
    relu_en      = r;
    @(posedge clk); #1;
    start        = 1'b0;
    total_words  = '0;
    shift_amount = '0;
    relu_en      = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [6:0] x, input logic [6:0] y,
                      input logic [3:0] ch, input logic [15:0] ed, input logic [17:0] ea);
    logic rdy;
    rdy          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_ch    = ch;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        sb.push_back('{addr: ea, data: ed});
        break;
      end
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for data 0x%0h, required acceptance", d);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_done: no done pulse within 100 cycles, required one", name);
    end else begin
      check({name, "_done_lat"}, 32'(cyc - last_hs_cyc), 32'd1);
    end
    @(negedge clk);
    check({name, "_done_1cyc"}, 32'(done), 32'd0);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] d4 [6] = '{32'hFFFF_FFE8, 32'd7, 32'd8, 32'h0000_1000, 32'd12, 32'hFFFF_FFF7};
  logic [15:0] e4 [6] = '{16'hFFFD, 16'h0001, 16'h0001, 16'h0200, 16'h0002, 16'hFFFF};

  initial begin
    arst_n_in     = 1'b0;
    start         = 1'b0;
    total_words   = '0;
    shift_amount  = '0;
    relu_en       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_ch     = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_data", 32'($unsigned(bus.out_data)), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    @(posedge clk); #1;

    // Rounding: 296/16 = 18.5 -> 19; address of (x3,y2,ch5) = 4149.
    begin_layer(24'd1, 5'd4, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    send(32'h0000_0128, 7'd3, 7'd2, 4'd5, 16'h0013, 18'd4149);
    check("t1_latency", 32'(bus.out_valid), 32'd1);
    wait_done("t1");

    // Saturation both ways, small negative passthrough, corner addresses.
    begin_layer(24'd3, 5'd0, 1'b0);
    send(32'h7FFF_FFFF, 7'd0,   7'd0,   4'd0,  16'h7FFF, 18'd0);
    send(32'h8000_0000, 7'd127, 7'd127, 4'd15, 16'h8000, 18'd262143);
    send(32'hFFFF_FFFB, 7'd1,   7'd0,   4'd0,  16'hFFFB, 18'd16);
    wait_done("t2");

    // ReLU clamps the most negative input; accept count caps in_ready below FIFO capacity.
    bus.out_ready = 1'b0;
    begin_layer(24'd2, 5'd3, 1'b1);
    send(32'h8000_0000, 7'd2, 7'd0, 4'd0, 16'h0000, 18'd32);
    send(32'd100,       7'd0, 7'd1, 4'd0, 16'h000D, 18'd2048);
    @(negedge clk);
    check("t3_cap_in_ready", 32'(bus.in_ready), 32'd0);
    check("t3_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("t3");

    // Backpressure: four words fill the FIFO, head stays stable, then drain in order.
    bus.out_ready = 1'b0;
    begin_layer(24'd6, 5'd3, 1'b0);
    for (int i = 0; i < 4; i++) send(d4[i], 7'(i), 7'd0, 4'd0, e4[i], 18'(i * 16));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_full_in_ready", 32'(bus.in_ready), 32'd0);
      check("t4_hold_data", 32'($unsigned(bus.out_data)), 32'(e4[0]));
      check("t4_hold_addr", 32'(bus.out_addr), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 4; i < 6; i++) send(d4[i], 7'(i), 7'd0, 4'd0, e4[i], 18'(i * 16));
    wait_done("t4");

    // Zero-length layer goes straight to DONE.
    begin_layer(24'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t5_done_1cyc", 32'(done), 32'd0);
    @(posedge clk); #1;

    // Reset mid-layer discards buffered words.
    bus.out_ready = 1'b0;
    begin_layer(24'd4, 5'd0, 1'b0);
    send(32'd11, 7'd0, 7'd0, 4'd0, 16'd11, 18'd0);
    send(32'd22, 7'd1, 7'd0, 4'd0, 16'd22, 18'd16);
    #2;
    arst_n_in = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_out_data", 32'($unsigned(bus.out_data)), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    arst_n_in     = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    begin_layer(24'd1, 5'd0, 1'b0);
    send(32'd33, 7'd4, 7'd0, 4'd0, 16'd33, 18'd64);
    wait_done("t6");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end
endmodule
